// File: rtl/fetch_issue_if.sv
// fetch_issue_if: bundles the instruction-memory and decode-side signals of
// the dual-issue fetch stage.
//   master : the fetch stage (drives requests and instruction pairs)
//   slave  : the environment (memory responses, stall, redirect)
// Signals:
//   o_imem_req / o_imem_addr : pair read request and 8-byte-aligned address
//   i_imem_rdata             : returned pair, slot0 = mem[addr], slot1 = mem[addr+4]
//   o_insts / o_pc / o_valid : instruction pair presented to decode
//   i_stall                  : decode not accepting this cycle
//   i_redirect / i_redirect_pc : flush and restart fetch at a new address
//   o_done                   : program fully fetched and drained
interface fetch_issue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                   o_imem_req;
  logic [ADDR_W-1:0]      o_imem_addr;
  logic [0:1][DATA_W-1:0] i_imem_rdata;
  logic [0:1][DATA_W-1:0] o_insts;
  logic [ADDR_W-1:0]      o_pc;
  logic                   o_valid;
  logic                   i_stall;
  logic                   i_redirect;
  logic [ADDR_W-1:0]      i_redirect_pc;
  logic                   o_done;

  modport master (
    output o_imem_req, o_imem_addr, o_insts, o_pc, o_valid, o_done,
    input  i_imem_rdata, i_stall, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_insts, o_pc, o_valid, o_done,
    output i_imem_rdata, i_stall, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/fetch_issue.sv
// fetch_issue: dual-issue instruction fetch stage.
// Walks a PC over instruction memory one 8-byte pair per request, buffers the
// returned pairs in a 2-entry queue and presents the head to decode. Supports
// branch redirect; all-zero words (NOP) are presented when nothing is valid.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : fetch_issue_if.master (memory request/response, decode pair,
//             stall, redirect, done)
// Optional build macro FETCH_TRACE_EN: prints consumed pairs, redirects and
// DONE entry with $display; functional behaviour is unchanged.
module fetch_issue #(
  parameter int ADDR_W     = 32,
  parameter int RESET_PC   = 0,
  parameter int PROG_BYTES = 64,
  parameter int DATA_W     = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_issue_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      pc;
  logic                   done_q;

  // request stage -> response stage
  logic                   inflight_p1;
  logic [ADDR_W-1:0]      inflight_pc_p1;

  // response stage -> queue / output
  logic [0:1][DATA_W-1:0] q_insts [0:1];
  logic [ADDR_W-1:0]      q_pc    [0:1];
  logic                   head;
  logic [1:0]             count;

  logic                   valid;
  logic                   consumed;
  logic                   push;
  logic                   tail;
  logic                   pc_in_prog;
  logic [2:0]             occupancy;
  logic                   req;
  logic                   drained;

  assign valid      = (count != 2'd0);
  assign consumed   = valid && !bus.i_stall;
  // A redirect discards the response landing in the same cycle.
  assign push       = inflight_p1 && !bus.i_redirect;
  // Tail slot: head when empty, the other slot when one entry is held.
  assign tail       = head ^ count[0];
  assign pc_in_prog = (pc < ADDR_W'(PROG_BYTES));
  // Entries that will be held next cycle if no new request is made; a new
  // request is only issued when its response is guaranteed a free slot.
  assign occupancy  = {1'b0, count} + 3'(inflight_p1) - 3'(consumed);
  assign req        = (state == S_RUN) && pc_in_prog && !bus.i_redirect &&
                      (occupancy < 3'd2);
  // Nothing in flight and the queue will be empty after this cycle's pop.
  assign drained    = !inflight_p1 && (occupancy == 3'd0);

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = pc;
  assign bus.o_valid     = valid;
  assign bus.o_insts     = valid ? q_insts[head] : '0;
  assign bus.o_pc        = valid ? q_pc[head]    : '0;
  assign bus.o_done      = done_q;

  // Control: FSM, PC, in-flight flag and queue pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      pc          <= ADDR_W'(RESET_PC);
      inflight_p1 <= 1'b0;
      head        <= 1'b0;
      count       <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      inflight_p1 <= req;
      if (req) pc <= pc + ADDR_W'(8);

      if (bus.i_redirect) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        count <= count + 2'(push) - 2'(consumed);
        if (consumed) head <= ~head;
      end

      case (state)
        S_IDLE:  state <= S_RUN;
        S_RUN:   if (!pc_in_prog) state <= S_DRAIN;
        S_DRAIN: if (drained) begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase

      // Redirect overrides the transitions above; IDLE still moves to RUN.
      if (bus.i_redirect) begin
        pc     <= {bus.i_redirect_pc[ADDR_W-1:3], 3'b000};
        done_q <= 1'b0;
        if (state != S_IDLE) state <= S_RUN;
      end
    end
  end

  // Data: request PC follows the request; returned pair lands at the tail.
  always_ff @(posedge i_clk) begin
    if (req) inflight_pc_p1 <= pc;
    if (push) begin
      q_insts[tail] <= bus.i_imem_rdata;
      q_pc[tail]    <= inflight_pc_p1;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (consumed)
        $display("FETCH pc=%h i0=%h i1=%h", bus.o_pc, bus.o_insts[0], bus.o_insts[1]);
      if (bus.i_redirect)
        $display("FETCH redirect %h", {bus.i_redirect_pc[ADDR_W-1:3], 3'b000});
      if (state == S_DRAIN && drained && !bus.i_redirect)
        $display("FETCH done");
    end
  end
`else
  // Trace output not built.
`endif

endmodule

// File: tb/tb_fetch_issue.sv
module tb_fetch_issue;

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  logic        last_req;
  logic [31:0] last_addr;

  fetch_issue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_issue #(
    .ADDR_W(32),
    .RESET_PC(0),
    .PROG_BYTES(32),
    .DATA_W(32)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: the word at byte address a is 0x10000000 + a.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc,
                            input logic [31:0] i0, input logic [31:0] i1,
                            input logic done);
    chk({tag, ".req"}, 64'(bus.o_imem_req), 64'(req));
    if (req) chk({tag, ".addr"}, 64'(bus.o_imem_addr), 64'(addr));
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'(vld));
    chk({tag, ".pc"},    64'(bus.o_pc),    64'(pc));
    chk({tag, ".i0"},    64'(bus.o_insts[0]), 64'(i0));
    chk({tag, ".i1"},    64'(bus.o_insts[1]), 64'(i1));
    chk({tag, ".done"},  64'(bus.o_done),  64'(done));
  endtask

  // One clock cycle: memory answers the previous cycle's request, inputs are
  // applied, then outputs settle for checking.
  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    bus.i_imem_rdata  = last_req ? {memw(last_addr), memw(last_addr + 32'd4)} : {BAD, BAD};
    bus.i_stall       = stall;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    #2;
    last_req  = bus.o_imem_req;
    last_addr = bus.o_imem_addr;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".req"},   64'(bus.o_imem_req),  64'd0);
    chk({tag, ".addr"},  64'(bus.o_imem_addr), 64'd0);
    chk({tag, ".valid"}, 64'(bus.o_valid),     64'd0);
    chk({tag, ".pc"},    64'(bus.o_pc),        64'd0);
    chk({tag, ".insts"}, 64'(bus.o_insts),     64'd0);
    chk({tag, ".done"},  64'(bus.o_done),      64'd0);
  endtask

  // Reset is asserted for a cycle and released 1 time unit after a rising
  // edge; the remainder of that cycle is cycle 0.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n             = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'd0;
    bus.i_imem_rdata  = {BAD, BAD};
    last_req          = 1'b0;
    #2;
    all_zero({tag, ".rst"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    #2;
    last_req  = bus.o_imem_req;
    last_addr = bus.o_imem_addr;
    expect_out({tag, ".c0"}, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    last_req  = 1'b0;
    last_addr = 32'd0;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'd0;
    bus.i_imem_rdata  = {BAD, BAD};

    // 1: straight run over 32 bytes
    do_reset("t1");
    step(0, 0, 0); expect_out("t1.c1", 1, 32'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t1.c2", 1, 32'h08, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t1.c3", 1, 32'h10, 1, 32'h00, 32'h1000_0000, 32'h1000_0004, 0);
    step(0, 0, 0); expect_out("t1.c4", 1, 32'h18, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(0, 0, 0); expect_out("t1.c5", 0, 0, 1, 32'h10, 32'h1000_0010, 32'h1000_0014, 0);
    step(0, 0, 0); expect_out("t1.c6", 0, 0, 1, 32'h18, 32'h1000_0018, 32'h1000_001C, 0);
    step(0, 0, 0); expect_out("t1.c7", 0, 0, 0, 0, 0, 0, 1);

    // redirect from DONE to an address past the program: RUN, DRAIN, DONE
    step(0, 1, 32'h40); expect_out("t1b.c8", 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0);      expect_out("t1b.c9", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0);      expect_out("t1b.c10", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0);      expect_out("t1b.c11", 0, 0, 0, 0, 0, 0, 1);

    // 2: stall cycles 4-6
    do_reset("t2");
    step(0, 0, 0); expect_out("t2.c1", 1, 32'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t2.c2", 1, 32'h08, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t2.c3", 1, 32'h10, 1, 32'h00, 32'h1000_0000, 32'h1000_0004, 0);
    step(1, 0, 0); expect_out("t2.c4", 0, 0, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(1, 0, 0); expect_out("t2.c5", 0, 0, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(1, 0, 0); expect_out("t2.c6", 0, 0, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(0, 0, 0); expect_out("t2.c7", 1, 32'h18, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(0, 0, 0); expect_out("t2.c8", 0, 0, 1, 32'h10, 32'h1000_0010, 32'h1000_0014, 0);
    step(0, 0, 0); expect_out("t2.c9", 0, 0, 1, 32'h18, 32'h1000_0018, 32'h1000_001C, 0);
    step(0, 0, 0); expect_out("t2.c10", 0, 0, 0, 0, 0, 0, 1);

    // 3 + 6: redirect in cycle 4 to 0x13; queue runs empty (NOP words)
    do_reset("t3");
    step(0, 0, 0); expect_out("t3.c1", 1, 32'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t3.c2", 1, 32'h08, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t3.c3", 1, 32'h10, 1, 32'h00, 32'h1000_0000, 32'h1000_0004, 0);
    step(0, 1, 32'h13); expect_out("t3.c4", 0, 0, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(0, 0, 0); expect_out("t3.c5", 1, 32'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t3.c6", 1, 32'h18, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t3.c7", 0, 0, 1, 32'h10, 32'h1000_0010, 32'h1000_0014, 0);
    step(0, 0, 0); expect_out("t3.c8", 0, 0, 1, 32'h18, 32'h1000_0018, 32'h1000_001C, 0);
    step(0, 0, 0); expect_out("t3.c9", 0, 0, 0, 0, 0, 0, 1);

    // 4: redirect and stall together in cycle 4
    do_reset("t4");
    step(0, 0, 0); expect_out("t4.c1", 1, 32'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t4.c2", 1, 32'h08, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t4.c3", 1, 32'h10, 1, 32'h00, 32'h1000_0000, 32'h1000_0004, 0);
    step(1, 1, 32'h13); expect_out("t4.c4", 0, 0, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);
    step(0, 0, 0); expect_out("t4.c5", 1, 32'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t4.c6", 1, 32'h18, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t4.c7", 0, 0, 1, 32'h10, 32'h1000_0010, 32'h1000_0014, 0);
    step(0, 0, 0); expect_out("t4.c8", 0, 0, 1, 32'h18, 32'h1000_0018, 32'h1000_001C, 0);
    step(0, 0, 0); expect_out("t4.c9", 0, 0, 0, 0, 0, 0, 1);

    // 5: reset mid-stream with the pair at 0x08 in flight
    do_reset("t5");
    step(0, 0, 0); expect_out("t5.c1", 1, 32'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t5.c2", 1, 32'h08, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("t5.async");
    #2;
    rst_n = 1'b1;
    cyc   = 0;
    step(0, 0, 0); expect_out("t5.r1", 1, 32'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t5.r2", 1, 32'h08, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_out("t5.r3", 1, 32'h10, 1, 32'h00, 32'h1000_0000, 32'h1000_0004, 0);
    step(0, 0, 0); expect_out("t5.r4", 1, 32'h18, 1, 32'h08, 32'h1000_0008, 32'h1000_000C, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
